// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage SECDED extended-Hamming engine.
// Each transaction either encodes a data word into a codeword or decodes,
// corrects and classifies a received codeword. Valid/ready on both sides,
// plus saturating counters of corrected and uncorrectable decode results.
module hamming_secded_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    // Smallest P with 2^P >= DATA_W + P + 1, written out for widths 1..57.
    localparam int P = (DATA_W <= 1)  ? 2 :
                       (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 : 6,
    localparam int N = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_modo,
    input  logic [DATA_W-1:0] in_data,
    input  logic [N-1:0]      in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [N-1:0]      out_code,
    output logic [P:0]        out_sindrome,
    output logic [1:0]        out_err,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_dbl,
    input  logic              cnt_clr
);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CORR = 2'b01;
    localparam logic [1:0] ERR_DBL  = 2'b10;

    // Stage 1 state
    logic              s1_valid;
    logic              s1_modo;
    logic [DATA_W-1:0] s1_data;
    logic [N-1:0]      s1_code;
    logic [P-1:0]      s1_s;
    logic              s1_g;

    // Combinational helpers
    logic              s1_adv;
    logic [P-1:0]      syn;
    logic              glob;
    logic [N-1:0]      placed;
    logic [P-1:0]      enc_syn;
    logic [N-1:0]      enc_code;
    logic [N-1:0]      flip_mask;
    logic [N-1:0]      corr_code;
    logic [1:0]        dec_err;
    logic [DATA_W-1:0] ext;
    logic              deliver;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign deliver  = out_valid && out_ready;

    // Static data-bit <-> codeword-slot wiring. A non-power-of-two position
    // pos carries data bit pos - clog2(pos) - 1 (positions below it that are
    // not powers of two). Parity and global slots of the placement are zero.
    for (genvar pos = 1; pos < N; pos++) begin : g_slot
        if ((pos & (pos - 1)) == 0) begin : g_par
            assign placed[pos-1] = 1'b0;
        end else begin : g_dat
            localparam int IDX = pos - $clog2(pos) - 1;
            assign placed[pos-1] = s1_data[IDX];
            assign ext[IDX]      = corr_code[pos-1];
        end
    end
    assign placed[N-1] = 1'b0;

    // Syndrome and overall parity of the incoming word.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        syn = '0;
        for (int pos = 1; pos < N; pos++) begin
            if (in_code[pos-1]) syn = syn ^ P'(pos);
        end
        glob = ^in_code;
    end

    // Stage 1 occupancy: refills whenever the slot is free or moving on.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= only, so all flops sample together.
        if (rst) s1_valid <= 1'b0;
        else if (in_ready) s1_valid <= in_valid;
    end

    // Stage 1 payload, captured on accept.
    always_ff @(posedge clk) begin
        // NOTE: payload is qualified by s1_valid, so it needs no reset.
        if (in_valid && in_ready) begin
            s1_modo <= in_modo;
            s1_data <= in_data;
            s1_code <= in_code;
            s1_s    <= syn;
            s1_g    <= glob;
        end
    end

    // Encode: the parity bits equal the syndrome of the data-only placement,
    // which drives the finished word's syndrome to zero.
    always_comb begin
        enc_syn = '0;
        for (int pos = 1; pos < N; pos++) begin
            if (placed[pos-1]) enc_syn = enc_syn ^ P'(pos);
        end
        enc_code = placed;
        for (int k = 0; k < P; k++) enc_code[(1 << k) - 1] = enc_syn[k];
        enc_code[N-1] = ^enc_code[N-2:0];
    end

    // Decode: classify {G,S} and flip at most one bit.
    always_comb begin
        flip_mask = '0;
        for (int pos = 1; pos < N; pos++) begin
            if (s1_s == P'(pos)) flip_mask[pos-1] = 1'b1;
        end
        corr_code = s1_code;
        dec_err   = ERR_NONE;
        if (s1_g) begin
            if (s1_s == '0) begin
                corr_code[N-1] = ~s1_code[N-1];
                dec_err        = ERR_CORR;
            end else if (|flip_mask) begin
                corr_code = s1_code ^ flip_mask;
                dec_err   = ERR_CORR;
            end else begin
                dec_err = ERR_DBL;
            end
        end else if (s1_s != '0) begin
            dec_err = ERR_DBL;
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_code     <= '0;
            out_sindrome <= '0;
            out_err      <= ERR_NONE;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_modo) begin
                    out_data     <= ext;
                    out_code     <= corr_code;
                    out_sindrome <= {s1_g, s1_s};
                    out_err      <= dec_err;
                end else begin
                    out_data     <= s1_data;
                    out_code     <= enc_code;
                    out_sindrome <= '0;
                    out_err      <= ERR_NONE;
                end
            end
        end
    end

    // Saturating error counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_corr <= '0;
            cnt_dbl  <= '0;
        end else if (deliver) begin
            if (out_err == ERR_CORR && cnt_corr != '1) cnt_corr <= cnt_corr + 1'b1;
            if (out_err == ERR_DBL && cnt_dbl != '1) cnt_dbl <= cnt_dbl + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb_hamming_secded_pipe: scoreboard bench for hamming_secded_pipe.
// Instance A: DATA_W=4, CNT_W=8. Instance B: DATA_W=5, CNT_W=2.
`timescale 1ns/1ps
module tb_hamming_secded_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] code;
        logic [31:0] synd;
        logic [1:0]  err;
        logic        dec;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic       rst_a, in_valid_a, in_ready_a, in_modo_a, out_valid_a, out_ready_a, cnt_clr_a;
    logic [3:0] in_data_a, out_data_a, out_sindrome_a;
    logic [7:0] in_code_a, out_code_a, cnt_corr_a, cnt_dbl_a;
    logic [1:0] out_err_a;

    // Instance B signals
    logic       rst_b, in_valid_b, in_ready_b, in_modo_b, out_valid_b, out_ready_b, cnt_clr_b;
    logic [4:0] in_data_b, out_data_b, out_sindrome_b;
    logic [9:0] in_code_b, out_code_b;
    logic [1:0] out_err_b, cnt_corr_b, cnt_dbl_b;

    hamming_secded_pipe #(.DATA_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_modo(in_modo_a), .in_data(in_data_a), .in_code(in_code_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_code(out_code_a), .out_sindrome(out_sindrome_a), .out_err(out_err_a),
        .cnt_corr(cnt_corr_a), .cnt_dbl(cnt_dbl_a), .cnt_clr(cnt_clr_a)
    );

    hamming_secded_pipe #(.DATA_W(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_modo(in_modo_b), .in_data(in_data_b), .in_code(in_code_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_code(out_code_b), .out_sindrome(out_sindrome_b), .out_err(out_err_b),
        .cnt_corr(cnt_corr_b), .cnt_dbl(cnt_dbl_b), .cnt_clr(cnt_clr_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model (straight from the code definition) ----------------
    function automatic bit is_pow2(input int v);
        return (v & (v - 1)) == 0;
    endfunction

    function automatic int ref_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic logic [31:0] ref_encode(input int dw, input logic [31:0] d);
        int n, j;
        logic [31:0] cw;
        bit par;
        n = dw + ref_p(dw) + 1;
        cw = '0;
        j = 0;
        for (int pos = 1; pos < n; pos++)
            if (!is_pow2(pos)) begin cw[pos-1] = d[j]; j++; end
        for (int k = 0; (1 << k) < n; k++) begin
            par = 0;
            for (int pos = 1; pos < n; pos++)
                if (!is_pow2(pos) && ((pos >> k) & 1) == 1) par ^= cw[pos-1];
            cw[(1 << k) - 1] = par;
        end
        par = 0;
        for (int i = 0; i < n - 1; i++) par ^= cw[i];
        cw[n-1] = par;
        return cw;
    endfunction

    function automatic exp_t ref_decode(input int dw, input logic [31:0] c);
        exp_t e;
        int n, p, s, j;
        bit g;
        logic [31:0] fixed;
        p = ref_p(dw);
        n = dw + p + 1;
        s = 0;
        g = 0;
        for (int i = 0; i < n; i++)
            if (c[i]) begin g = !g; if (i < n - 1) s ^= i + 1; end
        fixed = c;
        e.err = 2'd0;
        if (g && s == 0) begin fixed[n-1] = ~fixed[n-1]; e.err = 2'd1; end
        else if (g && s <= n - 1) begin fixed[s-1] = ~fixed[s-1]; e.err = 2'd1; end
        else if (g || s != 0) e.err = 2'd2;
        e.data = '0;
        j = 0;
        for (int pos = 1; pos < n; pos++)
            if (!is_pow2(pos)) begin e.data[j] = fixed[pos-1]; j++; end
        e.code = fixed;
        e.synd = (g ? (32'd1 << p) : 32'd0) | 32'(s);
        e.dec  = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [31:0] c, input logic [31:0] s,
                                input logic [1:0] err, input logic dec);
        exp_t e;
        e.data = d; e.code = c; e.synd = s; e.err = err; e.dec = dec;
        return e;
    endfunction

    // Valid codeword with 0, 1 or 2 flipped bits, or a fully random word.
    function automatic logic [31:0] rand_code(input int dw);
        int n, a, b, kind;
        logic [31:0] c;
        n = dw + ref_p(dw) + 1;
        kind = $urandom_range(0, 3);
        c = ref_encode(dw, $urandom);
        a = $urandom_range(0, n - 1);
        b = (a + 1 + $urandom_range(0, n - 2)) % n;
        if (kind >= 1) c[a] = ~c[a];
        if (kind == 2) c[b] = ~c[b];
        if (kind == 3) c = $urandom;
        return c & ((32'd1 << n) - 1);
    endfunction

    // ---------------- instance A monitor ----------------
    initial begin : mon_a
        exp_t e;
        logic [17:0] held;
        logic stalled;
        int ec, ed;
        stalled = 0; ec = 0; ed = 0; held = '0;
        forever begin
            @(negedge clk); #2;
            if (rst_a) begin
                q_a.delete(); ec = 0; ed = 0; stalled = 0;
            end else begin
                check("a_cnt_corr", cnt_corr_a, ec);
                check("a_cnt_dbl", cnt_dbl_a, ed);
                if (stalled)
                    check("a_hold", {out_data_a, out_code_a, out_sindrome_a, out_err_a}, held);
                if (out_valid_a && out_ready_a) begin
                    if (q_a.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL a_extra_output: got code %0h, expected no output", out_code_a);
                    end else begin
                        e = q_a.pop_front();
                        check("a_data", out_data_a, e.data);
                        check("a_code", out_code_a, e.code);
                        check("a_synd", out_sindrome_a, e.synd);
                        check("a_err", out_err_a, e.err);
                        if (e.dec && e.err == 2'd1 && ec < 255) ec++;
                        if (e.dec && e.err == 2'd2 && ed < 255) ed++;
                    end
                end
                if (cnt_clr_a) begin ec = 0; ed = 0; end
                stalled = out_valid_a && !out_ready_a;
                held = {out_data_a, out_code_a, out_sindrome_a, out_err_a};
            end
        end
    end

    // ---------------- instance B monitor ----------------
    initial begin : mon_b
        exp_t e;
        int ec, ed;
        ec = 0; ed = 0;
        forever begin
            @(negedge clk); #2;
            if (rst_b) begin
                q_b.delete(); ec = 0; ed = 0;
            end else begin
                check("b_cnt_corr", cnt_corr_b, ec);
                check("b_cnt_dbl", cnt_dbl_b, ed);
                if (out_valid_b && out_ready_b) begin
                    if (q_b.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL b_extra_output: got code %0h, expected no output", out_code_b);
                    end else begin
                        e = q_b.pop_front();
                        check("b_data", out_data_b, e.data);
                        check("b_code", out_code_b, e.code);
                        check("b_synd", out_sindrome_b, e.synd);
                        check("b_err", out_err_b, e.err);
                        if (e.dec && e.err == 2'd1 && ec < 3) ec++;
                        if (e.dec && e.err == 2'd2 && ed < 3) ed++;
                    end
                end
                if (cnt_clr_b) begin ec = 0; ed = 0; end
            end
        end
    end

    // ---------------- instance A driver tasks ----------------
    int rdy_mode_a = 0;
    int clr_mode_a = 0;
    int stall_a    = 0;

    task automatic tick_a();
        @(negedge clk);
        if (stall_a > 0) begin out_ready_a = 1'b0; stall_a--; end
        else if (rdy_mode_a != 0) out_ready_a = ($urandom_range(0, 3) != 0);
        else out_ready_a = 1'b1;
        cnt_clr_a = (clr_mode_a != 0) && ($urandom_range(0, 15) == 0);
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin tick_a(); in_valid_a = 1'b0; end
    endtask

    task automatic issue_a(input logic modo, input logic [3:0] d, input logic [7:0] c,
                           input exp_t e, output int waited);
        waited = 0;
        forever begin
            tick_a();
            in_valid_a = 1'b1; in_modo_a = modo; in_data_a = d; in_code_a = c;
            #1;
            if (in_ready_a) begin q_a.push_back(e); break; end
            waited++;
            if (waited > 50) begin timeout("a_accept"); in_valid_a = 1'b0; break; end
        end
    endtask

    task automatic drain_a();
        int k;
        k = 0;
        while (q_a.size() != 0 && k < 200) begin idle_a(1); k++; end
        if (q_a.size() != 0) begin timeout("a_drain"); q_a.delete(); end
        idle_a(1);
        #1;
    endtask

    // ---------------- instance B driver tasks ----------------
    task automatic issue_b(input logic modo, input logic [4:0] d, input logic [9:0] c, input exp_t e);
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            in_valid_b = 1'b1; in_modo_b = modo; in_data_b = d; in_code_b = c;
            #1;
            if (in_ready_b) begin q_b.push_back(e); break; end
            waited++;
            if (waited > 50) begin timeout("b_accept"); in_valid_b = 1'b0; break; end
        end
    endtask

    task automatic drain_b();
        int k;
        k = 0;
        while (q_b.size() != 0 && k < 200) begin @(negedge clk); in_valid_b = 1'b0; k++; end
        if (q_b.size() != 0) begin timeout("b_drain"); q_b.delete(); end
        @(negedge clk); in_valid_b = 1'b0;
        #1;
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w, t0, t9;
        logic [31:0] d, c;
        exp_t e;
        bit found;

        rst_a = 1; in_valid_a = 0; in_modo_a = 0; in_data_a = '0; in_code_a = '0;
        out_ready_a = 1; cnt_clr_a = 0;
        rst_b = 1; in_valid_b = 0; in_modo_b = 0; in_data_b = '0; in_code_b = '0;
        out_ready_b = 1; cnt_clr_b = 0;
        repeat (2) @(negedge clk);
        rst_a = 0; rst_b = 0;
        #1;
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_in_ready_a", in_ready_a, 1);
        check("rst_outputs_a", {out_data_a, out_code_a, out_sindrome_a, out_err_a}, 0);
        check("rst_out_valid_b", out_valid_b, 0);
        check("rst_in_ready_b", in_ready_b, 1);

        // Encode 1011 -> 0x55, with two-cycle latency.
        issue_a(1'b0, 4'b1011, 8'h00, mk(32'hB, 32'h55, 0, 2'd0, 1'b0), w);
        idle_a(1); #1;
        check("lat_cycle1_out_valid", out_valid_a, 0);
        idle_a(1); #1;
        check("lat_cycle2_out_valid", out_valid_a, 1);
        drain_a();

        // Clean decode leaves counters alone.
        issue_a(1'b1, 4'h0, 8'h55, mk(32'hB, 32'h55, 32'b0000, 2'd1 - 2'd1, 1'b1), w);
        drain_a();
        check("clean_cnt_corr", cnt_corr_a, 0);
        check("clean_cnt_dbl", cnt_dbl_a, 0);

        // Single error at position 5.
        issue_a(1'b1, 4'h0, 8'h45, mk(32'hB, 32'h55, 32'b1101, 2'd1, 1'b1), w);
        drain_a();
        check("single_cnt_corr", cnt_corr_a, 1);

        // Global-bit error, then a double error.
        issue_a(1'b1, 4'h0, 8'hD5, mk(32'hB, 32'h55, 32'b1000, 2'd1, 1'b1), w);
        issue_a(1'b1, 4'h0, 8'h44, mk(32'h9, 32'h44, 32'b0100, 2'd2, 1'b1), w);
        drain_a();
        check("global_cnt_corr", cnt_corr_a, 2);
        check("double_cnt_dbl", cnt_dbl_a, 1);

        // Ten back-to-back decodes with a three-cycle consumer stall mid-stream.
        t0 = 0; t9 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) stall_a = 3;
            c = rand_code(4);
            issue_a(1'b1, 4'($urandom), c[7:0], ref_decode(4, c), w);
            if (i == 0) t0 = cyc;
            if (i == 9) t9 = cyc;
            check("stream_wait", w, (i == 5) ? 3 : 0);
        end
        check("stream_span", t9 - t0, 12);
        drain_a();

        // Reset mid-stream discards everything in flight.
        for (int i = 0; i < 4; i++) begin
            c = rand_code(4);
            issue_a(1'b1, 4'h0, c[7:0], ref_decode(4, c), w);
        end
        tick_a(); rst_a = 1; in_valid_a = 0;
        tick_a(); rst_a = 0; #1;
        check("midrst_out_valid", out_valid_a, 0);
        check("midrst_outputs", {out_data_a, out_code_a, out_sindrome_a, out_err_a}, 0);
        check("midrst_counters", {cnt_corr_a, cnt_dbl_a}, 0);
        check("midrst_in_ready", in_ready_a, 1);
        for (int i = 0; i < 3; i++) begin
            idle_a(1); #1;
            check("midrst_no_output", out_valid_a, 0);
        end

        // Random mix of encodes and decodes with random backpressure and clears.
        rdy_mode_a = 1; clr_mode_a = 1;
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                issue_a(1'b0, d[3:0], 8'($urandom),
                        mk(d & 32'hF, ref_encode(4, d), 0, 2'd0, 1'b0), w);
            end else begin
                c = rand_code(4);
                issue_a(1'b1, d[3:0], c[7:0], ref_decode(4, c), w);
            end
            if ($urandom_range(0, 2) == 0) idle_a(1);
        end
        rdy_mode_a = 0; clr_mode_a = 0;
        drain_a();

        // Instance B: counter saturation at 3 after five single errors.
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            c = ref_encode(5, d);
            c[$urandom_range(0, 9)] ^= 1'b1;
            issue_b(1'b1, 5'h0, c[9:0], ref_decode(5, c));
        end
        drain_b();
        check("b_sat_cnt_corr", cnt_corr_b, 3);

        // Clear in the same cycle a corrected result is delivered.
        c = ref_encode(5, 32'h15);
        c[2] ^= 1'b1;
        issue_b(1'b1, 5'h0, c[9:0], ref_decode(5, c));
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk); in_valid_b = 0; #1;
            if (out_valid_b) begin cnt_clr_b = 1; found = 1; end
        end
        if (!found) timeout("b_clr_deliver");
        @(negedge clk); cnt_clr_b = 0; #1;
        check("b_clr_priority", cnt_corr_b, 0);

        // G=1 with S=12 on a 10-bit word is uncorrectable.
        issue_b(1'b1, 5'h0, 10'h091, mk(32'b00010, 32'h091, 32'b11100, 2'd2, 1'b1));
        drain_b();
        check("b_s12_cnt_dbl", cnt_dbl_b, 1);

        // Random traffic on instance B.
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                issue_b(1'b0, d[4:0], 10'($urandom),
                        mk(d & 32'h1F, ref_encode(5, d), 0, 2'd0, 1'b0));
            end else begin
                c = rand_code(5);
                issue_b(1'b1, d[4:0], c[9:0], ref_decode(5, c));
            end
        end
        drain_b();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
- Parametrised SECDED Hamming engine. It is the successor of the fixed 4-bit reference-syndrome block.
- Each transaction, selected per transaction, either encodes a data word into an extended Hamming codeword or decodes, corrects and classifies a received codeword.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Saturating error counters feed the display/status logic of the checker datapath.

Parameters:
- DATA_W, 4: data word width, 2..26 supported.
- P, derived (not overridable), 3 for default: smallest P with 2^P >= DATA_W+P+1.
- N, derived (not overridable), 8 for default: DATA_W+P+1, codeword width including global parity.
- CNT_W, 8: width of each error counter.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block accepts input this cycle
in_modo  input  1  0 = encode, 1 = decode/correct
in_data  input  DATA_W  data word (encode mode)
in_code  input  N  received codeword (decode mode)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  encode: in_data echoed; decode: corrected data
out_code  output  N  encode: codeword; decode: corrected codeword
out_sindrome  output  P+1  {G, S[P-1:0]}; all zero in encode mode
out_err  output  2  00 clean, 01 single corrected, 10 double/uncorrectable; 00 in encode mode
cnt_corr  output  CNT_W  count of single-corrected results
cnt_dbl  output  CNT_W  count of uncorrectable results
cnt_clr  input  1  synchronous clear of both counters

Behaviour:
Reset:
- out_valid=0, all internal stage valids=0, cnt_corr=0, cnt_dbl=0.
- out_data, out_code, out_sindrome, out_err=0.
- in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight transactions and delivers no partial output.

Codeword layout:
- Bit i (0 <= i <= N-2) holds Hamming position i+1. Parity bits sit at power-of-two positions; data bits d[0], d[1], ... fill the remaining positions in ascending order.
- Bit N-1 is global parity: XOR of bits 0..N-2.
- Parity at position 2^k = XOR of all data positions with bit k set.

Decode:
- S = XOR of position indices of all set bits in 0..N-2 (P bits).
- G = XOR of all N bits.
- Classification:
  - G=0, S=0: err=00, no change.
  - G=1, S=0: global bit in error. Flip bit N-1, err=01.
  - G=1, 1 <= S <= N-1: flip bit S-1, err=01.
  - G=1, S > N-1: err=10, no change.
  - G=0, S != 0: err=10, no change; out_data is the raw extracted data.

Pipeline:
- Stage 1 registers mode and inputs plus S and G.
- Stage 2 registers the corrected/encoded result.
- Latency is exactly 2 cycles from the accept edge to out_valid when out_ready=1.
- Throughput is 1 per cycle with no bubbles under continuous flow.
- Handshake rules:
  - Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
  - in_ready = !s1_valid || s1 advancing. s1 advances when !out_valid || out_ready. The combinational path out_ready -> in_ready is permitted.
  - While out_valid && !out_ready, all outputs are held stable and nothing is overwritten. Ordering is preserved.

Counters:
- Update on each delivered decode result: cnt_corr +1 on err=01, cnt_dbl +1 on err=10.
- Both saturate at 2^CNT_W-1.
- cnt_clr has priority over a same-cycle increment (result 0).
- Encode results never count.

Test Plan:
1. DATA_W=4, encode in_data=4'b1011 -> out_code=8'h55, out_sindrome=0, out_err=00, 2 cycles after accept.
2. Decode in_code=8'h55 -> out_data=4'b1011, out_sindrome=4'b0000, out_err=00, counters unchanged.
3. Decode 8'h45 (bit 4 flipped) -> out_code=8'h55, out_data=4'b1011, out_sindrome=4'b1101, out_err=01, cnt_corr=1.
4. Decode 8'hD5 (global bit flipped) -> out_code=8'h55, out_sindrome=4'b1000, err=01. Then decode 8'h44 (double) -> out_sindrome=4'b0100, err=10, cnt_dbl=1.
5. Stream 10 back-to-back decodes with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs are held stable, all 10 results arrive in order, none are lost or duplicated. Assert rst mid-stream -> out_valid=0 next cycle and counters=0.
6. CNT_W=2: deliver 5 single errors -> cnt_corr saturates at 3. Assert cnt_clr on the same cycle as a delivered corrected result -> cnt_corr=0. Also run DATA_W=5 (N=10): decode with G=1 and S=12 -> err=10.
